// File: rtl/mu0_pkg.sv
// Shared definitions for the MU0 core: widths, opcodes, FSM states and ALU operations.
package mu0_pkg;

  localparam int MU0_ADDR_W = 12;
  localparam int MU0_DATA_W = 16;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STO = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_SUB  = 2'd2
  } alu_op_e;

endpackage

// File: rtl/mu0_if.sv
// Memory-side control signals of the MU0 core; the data bus stays a separate inout port.
interface mu0_if
  import mu0_pkg::*;
#(
  parameter int ADDR_W = MU0_ADDR_W
);

  logic [ADDR_W-1:0] addr;
  logic              MEMrq;
  logic              RnW;

  modport master (output addr, output MEMrq, output RnW);
  modport slave  (input  addr, input  MEMrq, input  RnW);

endinterface

// File: rtl/mu0_alu.sv
// Combinational accumulator datapath: pass the memory word, or add/subtract it from ACC.
module mu0_alu
  import mu0_pkg::*;
#(
  parameter int DATA_W = MU0_DATA_W
) (
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = b;
    unique case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      default: y = b;
    endcase
  end

endmodule

// File: rtl/mu0_cpu.sv
// Multi-cycle MU0 core: two-cycle FETCH/EXEC sequencing, terminal HALT, and the
// tri-state driver for the shared program/data bus.
module mu0_cpu
  import mu0_pkg::*;
#(
  parameter int                ADDR_W   = MU0_ADDR_W,
  parameter int                DATA_W   = MU0_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  mu0_if.master             bus,
  inout  wire  [DATA_W-1:0] data,
  output logic              STP_flag,
  output logic [DATA_W-1:0] acc_out,
  output logic [ADDR_W-1:0] pc_out
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              stp_q, stp_d;

  logic              mem_rq;
  logic              rnw;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  alu_op_e           alu_op;
  logic [DATA_W-1:0] alu_y;

  assign opcode  = ir_q[DATA_W-1 -: 4];
  assign operand = ir_q[ADDR_W-1:0];

  mu0_alu #(.DATA_W(DATA_W)) u_alu (
    .op (alu_op),
    .a  (acc_q),
    .b  (data),
    .y  (alu_y)
  );

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    acc_d    = acc_q;
    stp_d    = stp_q;
    mem_rq   = 1'b0;
    rnw      = 1'b1;
    mem_addr = pc_q;
    alu_op   = ALU_PASS;

    unique case (state_q)
      S_FETCH: begin
        mem_rq  = 1'b1;
        ir_d    = data;
        pc_d    = pc_q + PC_STEP;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        mem_addr = operand;
        state_d  = S_FETCH;
        case (opcode)
          OP_LDA: begin
            mem_rq = 1'b1;
            acc_d  = alu_y;
          end
          OP_STO: begin
            mem_rq = 1'b1;
            rnw    = 1'b0;
          end
          OP_ADD: begin
            mem_rq = 1'b1;
            alu_op = ALU_ADD;
            acc_d  = alu_y;
          end
          OP_SUB: begin
            mem_rq = 1'b1;
            alu_op = ALU_SUB;
            acc_d  = alu_y;
          end
          OP_JMP: pc_d = operand;
          OP_JGE: if (!acc_q[DATA_W-1]) pc_d = operand;
          OP_JNE: if (acc_q != '0) pc_d = operand;
          OP_STP: begin
            stp_d   = 1'b1;
            state_d = S_HALT;
          end
          default: ;
        endcase
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase

    // The bus must stay quiet while reset is held, whatever state the core was in.
    if (rst) begin
      mem_rq = 1'b0;
      rnw    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is tested inside the clocked block and not in the sensitivity list.
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      acc_q   <= '0;
      stp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      stp_q   <= stp_d;
    end
  end

  assign bus.addr  = mem_addr;
  assign bus.MEMrq = mem_rq;
  assign bus.RnW   = rnw;

  assign data = (mem_rq && !rnw) ? acc_q : 'z;

  assign STP_flag = stp_q;
  assign acc_out  = acc_q;
  assign pc_out   = pc_q;

endmodule
